// File: rtl/span_sched_pkg.sv
// Shared types and defaults for the span scheduler: FSM states, latched span payload,
// and the default writer watchdog limit.
package span_sched_pkg;

    localparam int unsigned SpanW          = 16;
    localparam int unsigned DefaultTimeout = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StLaunch,
        StWait,
        StRelease
    } sched_state_e;

    typedef struct packed {
        logic [SpanW-1:0] x0;
        logic [SpanW-1:0] y0;
        logic [SpanW-1:0] x1;
        logic [SpanW-1:0] y1;
        logic [SpanW-1:0] z1;
        logic [SpanW-1:0] z2;
    } span_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from rr_ptr_i + 1,
// wrapping at N_REQ.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IdxW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  rr_ptr_i,
    output logic             valid_o,
    output logic [IdxW-1:0]  idx_o
);

    always_comb begin
        logic [IdxW-1:0] cand;
        cand    = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        // i = N_REQ revisits rr_ptr_i itself last, so a lone requester is still served.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IdxW'((32'(rr_ptr_i) + i) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/span_scheduler.sv
// Shares one span writer between N_REQ producers: round-robin grant, start pulse, plot count,
// per-requester ack. Degenerate spans (x1 < x0) bypass the writer; a watchdog aborts a hung one.
module span_scheduler
    import span_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = SpanW,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         x0_in,
    input  logic [N_REQ*W-1:0]         y0_in,
    input  logic [N_REQ*W-1:0]         x1_in,
    input  logic [N_REQ*W-1:0]         y1_in,
    input  logic [N_REQ*W-1:0]         z1_in,
    input  logic [N_REQ*W-1:0]         z2_in,
    output logic [N_REQ-1:0]           ack,
    output logic [W-1:0]               pix_count,
    output logic                       span_start,
    output logic [W-1:0]               span_x0,
    output logic [W-1:0]               span_y0,
    output logic [W-1:0]               span_x1,
    output logic [W-1:0]               span_y1,
    output logic [W-1:0]               span_z1,
    output logic [W-1:0]               span_z2,
    input  logic                       span_plot,
    input  logic                       span_done,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       timeout_err
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned WdW  = $clog2(TIMEOUT);

    // The payload struct is fixed-width, so the coordinate width must match it.
    if (W != SpanW) begin : g_width_check
        $error("span_scheduler: W must equal span_sched_pkg::SpanW");
    end

    sched_state_e     state_q;
    span_t            span_q;
    logic [IdxW-1:0]  grant_q;
    logic [IdxW-1:0]  rr_ptr_q;
    logic [N_REQ-1:0] holdoff_q;
    logic [N_REQ-1:0] ack_q;
    logic [W-1:0]     cnt_q;
    logic [W-1:0]     pix_q;
    logic [WdW-1:0]   wdog_q;
    logic             start_q;
    logic             busy_q;
    logic             tmo_q;

    span_t            req_span [N_REQ];
    logic [N_REQ-1:0] req_masked;
    logic             arb_valid;
    logic [IdxW-1:0]  arb_idx;
    logic [W-1:0]     cnt_inc;
    logic [N_REQ-1:0] grant_oh;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_span[g] = '{
            x0: x0_in[g*W +: W],
            y0: y0_in[g*W +: W],
            x1: x1_in[g*W +: W],
            y1: y1_in[g*W +: W],
            z1: z1_in[g*W +: W],
            z2: z2_in[g*W +: W]
        };
    end

    assign req_masked = req & ~holdoff_q;
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign grant_oh   = N_REQ'(1) << grant_q;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i    (req_masked),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (arb_valid),
        .idx_o    (arb_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            span_q    <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            holdoff_q <= '0;
            ack_q     <= '0;
            cnt_q     <= '0;
            pix_q     <= '0;
            wdog_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            ack_q   <= '0;
            start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Hold-off only ever covers the first IDLE cycle after a release.
                    holdoff_q <= '0;
                    if (arb_valid) begin
                        span_q  <= req_span[arb_idx];
                        grant_q <= arb_idx;
                        busy_q  <= 1'b1;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (span_q.x1 < span_q.x0) begin
                        pix_q   <= '0;
                        ack_q   <= grant_oh;
                        state_q <= StRelease;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= StLaunch;
                    end
                end
                StLaunch: begin
                    cnt_q   <= '0;
                    wdog_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (span_done) begin
                        pix_q   <= span_plot ? cnt_inc : cnt_q;
                        ack_q   <= grant_oh;
                        state_q <= StRelease;
                    end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        pix_q   <= cnt_q;
                        ack_q   <= grant_oh;
                        state_q <= StRelease;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                        if (span_plot) begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                StRelease: begin
                    rr_ptr_q  <= grant_q;
                    holdoff_q <= grant_oh;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign pix_count   = pix_q;
    assign span_start  = start_q;
    assign span_x0     = span_q.x0;
    assign span_y0     = span_q.y0;
    assign span_x1     = span_q.x1;
    assign span_y1     = span_q.y1;
    assign span_z1     = span_q.z1;
    assign span_z2     = span_q.z2;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_span_scheduler.sv
// Scoreboard bench for span_scheduler: stimulus queues expected launches and acks, a monitor
// pops and compares them whenever the DUT pulses span_start or ack.
module tb_span_scheduler;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 16;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] x0_in = '0;
    logic [N*W-1:0] y0_in = '0;
    logic [N*W-1:0] x1_in = '0;
    logic [N*W-1:0] y1_in = '0;
    logic [N*W-1:0] z1_in = '0;
    logic [N*W-1:0] z2_in = '0;
    logic [N-1:0]   ack;
    logic [W-1:0]   pix_count;
    logic           span_start;
    logic [W-1:0]   span_x0, span_y0, span_x1, span_y1, span_z1, span_z2;
    logic           span_plot;
    logic           span_done;
    logic           busy;
    logic [1:0]     grant_id;
    logic           timeout_err;

    span_scheduler #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .x0_in       (x0_in),
        .y0_in       (y0_in),
        .x1_in       (x1_in),
        .y1_in       (y1_in),
        .z1_in       (z1_in),
        .z2_in       (z2_in),
        .ack         (ack),
        .pix_count   (pix_count),
        .span_start  (span_start),
        .span_x0     (span_x0),
        .span_y0     (span_y0),
        .span_x1     (span_x1),
        .span_y1     (span_y1),
        .span_z1     (span_z1),
        .span_z2     (span_z2),
        .span_plot   (span_plot),
        .span_done   (span_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int x0, y0, x1, y1, z1, z2;
        int exp_cyc;   // -1: latency not checked
    } start_t;

    typedef struct {
        int id;
        int pix;
        int tmo;
        int mode;      // 0: no latency check, 1: exact cycle, 2: one cycle after writer done
        int exp_cyc;
    } ack_t;

    start_t sq[$];
    ack_t   aq[$];
    int     checks    = 0;
    int     errors    = 0;
    int     acks_seen = 0;
    int     done_cyc  = 0;
    bit     wr_hang   = 1'b0;
    bit     wr_last   = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic set_span(input int i, input int x0, input int y0, input int x1,
                            input int y1, input int z1, input int z2);
        x0_in[i*W +: W] = 16'(x0);
        y0_in[i*W +: W] = 16'(y0);
        x1_in[i*W +: W] = 16'(x1);
        y1_in[i*W +: W] = 16'(y1);
        z1_in[i*W +: W] = 16'(z1);
        z2_in[i*W +: W] = 16'(z2);
    endtask

    task automatic push_start(input int id, input int exp_cyc);
        start_t s;
        s.id = id;
        s.x0 = int'(x0_in[id*W +: W]);
        s.y0 = int'(y0_in[id*W +: W]);
        s.x1 = int'(x1_in[id*W +: W]);
        s.y1 = int'(y1_in[id*W +: W]);
        s.z1 = int'(z1_in[id*W +: W]);
        s.z2 = int'(z2_in[id*W +: W]);
        s.exp_cyc = exp_cyc;
        sq.push_back(s);
    endtask

    task automatic push_ack(input int id, input int pix, input int tmo, input int mode,
                            input int exp_cyc);
        ack_t a;
        a.id = id;
        a.pix = pix;
        a.tmo = tmo;
        a.mode = mode;
        a.exp_cyc = exp_cyc;
        aq.push_back(a);
    endtask

    // Returns on the posedge that ends the RELEASE cycle of the n-th ack.
    task automatic wait_acks(input int n, input int budget);
        int base;
        int k;
        base = acks_seen;
        k = 0;
        while (acks_seen < base + n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("acks_received", acks_seen - base, n);
    endtask

    // Writer model: plots x1-x0+1 pixels on consecutive cycles, then done (or done with the
    // last plot); in hang mode it plots 3 times and never signals done.
    initial begin
        int n;
        bit aborted;
        span_plot = 1'b0;
        span_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && span_start) begin
                n = wr_hang ? 3 : int'(span_x1) - int'(span_x0) + 1;
                aborted = 1'b0;
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    span_plot = 1'b1;
                    if (wr_last && !wr_hang && k == n - 1) begin
                        span_done = 1'b1;
                        done_cyc  = cyc;
                    end
                end
                if (!aborted) begin
                    @(negedge clk);
                    span_plot = 1'b0;
                    span_done = 1'b0;
                    if (!wr_hang && !wr_last && reset) begin
                        span_done = 1'b1;
                        done_cyc  = cyc;
                        @(negedge clk);
                    end
                end
                span_plot = 1'b0;
                span_done = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        start_t s;
        ack_t   a;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (span_start) begin
                    if (sq.size() == 0) begin
                        chk("unexpected_start", span_start, 0);
                    end else begin
                        s = sq.pop_front();
                        chk("start_grant_id", grant_id, s.id);
                        chk("span_x0", span_x0, s.x0);
                        chk("span_y0", span_y0, s.y0);
                        chk("span_x1", span_x1, s.x1);
                        chk("span_y1", span_y1, s.y1);
                        chk("span_z1", span_z1, s.z1);
                        chk("span_z2", span_z2, s.z2);
                        if (s.exp_cyc >= 0) chk("start_latency", cyc, s.exp_cyc);
                    end
                end
                if (ack != '0) begin
                    if (aq.size() == 0) begin
                        chk("unexpected_ack", ack, 0);
                    end else begin
                        a = aq.pop_front();
                        chk("ack_vector", ack, 1 << a.id);
                        chk("pix_count", pix_count, a.pix);
                        chk("timeout_err_at_ack", timeout_err, a.tmo);
                        if (a.mode == 1) chk("ack_latency", cyc, a.exp_cyc);
                        if (a.mode == 2) chk("done_to_ack", cyc, done_cyc + 1);
                    end
                    acks_seen++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int c0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_span_start", span_start, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_pix_count", pix_count, 0);
        reset = 1'b1;

        // Single span; payload change after the grant must not reach span_*.
        @(posedge clk); #1;
        set_span(0, 10, 5, 14, 5, 'h100, 'h200);
        push_start(0, cyc + 2);
        push_ack(0, 5, 0, 2, 0);
        req = 4'b0001;
        @(posedge clk); #1;
        x0_in[0 +: W] = 16'd999;
        wait_acks(1, 100);
        #1 req = '0;
        chk("busy_after_ack", busy, 0);

        // Fairness: all held, grants 1,2,3,0,1; done coincides with the last plot.
        wr_last = 1'b1;
        for (int i = 0; i < N; i++) set_span(i, i * 4, i, i * 4 + i + 1, i, 16 + i, 32 + i);
        foreach (sq[i]) ;
        begin
            int order [5];
            order = '{1, 2, 3, 0, 1};
            for (int j = 0; j < 5; j++) begin
                push_start(order[j], -1);
                push_ack(order[j], order[j] + 2, 0, 2, 0);
            end
        end
        @(posedge clk); #1;
        req = 4'b1111;
        wait_acks(5, 400);
        #1 req = '0;
        wr_last = 1'b0;

        // Degenerate span: no launch, ack three cycles after request.
        @(posedge clk); #1;
        set_span(2, 20, 7, 19, 7, 1, 2);
        push_ack(2, 0, 0, 1, cyc + 2);
        req = 4'b0100;
        wait_acks(1, 50);
        #1 req = '0;

        // Hold-off: req[1] stays high after its ack; regrant only after the masked cycle.
        @(posedge clk); #1;
        set_span(1, 1, 3, 2, 3, 5, 6);
        push_start(1, cyc + 2);
        push_ack(1, 2, 0, 2, 0);
        push_start(1, -1);
        push_ack(1, 2, 0, 2, 0);
        req = 4'b0010;
        wait_acks(1, 100);
        @(posedge clk); #1;
        chk("holdoff_no_regrant", busy, 0);
        @(posedge clk); #1;
        chk("holdoff_regrant_busy", busy, 1);
        chk("holdoff_regrant_id", grant_id, 1);
        wait_acks(1, 100);
        #1 req = '0;

        // Watchdog: writer hangs after 3 plots.
        wr_hang = 1'b1;
        @(posedge clk); #1;
        set_span(3, 0, 9, 7, 9, 3, 4);
        push_start(3, cyc + 2);
        push_ack(3, 3, 1, 1, cyc + 2 + TMO + 1);
        req = 4'b1000;
        wait_acks(1, 100);
        #1 req = '0;
        wr_hang = 1'b0;

        // timeout_err stays set across a following clean span.
        @(posedge clk); #1;
        set_span(2, 2, 4, 4, 4, 9, 9);
        push_start(2, cyc + 2);
        push_ack(2, 3, 1, 2, 0);
        req = 4'b0100;
        wait_acks(1, 100);
        #1 req = '0;
        chk("timeout_err_sticky", timeout_err, 1);

        // Async reset mid-WAIT after two plots: no ack, outputs clear without a clock edge.
        @(posedge clk); #1;
        set_span(3, 0, 2, 9, 2, 7, 8);
        c0 = cyc;
        push_start(3, c0 + 2);
        req = 4'b1000;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        req = '0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_span_start", span_start, 0);
        chk("arst_ack", ack, 0);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_span_x1", span_x1, 0);
        chk("arst_span_z2", span_z2, 0);
        chk("arst_timeout_err", timeout_err, 0);
        chk("arst_pix_count", pix_count, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // After reset rr_ptr is 0: with req[1] and req[3], 1 wins, then 3.
        @(posedge clk); #1;
        set_span(1, 5, 6, 7, 6, 1, 1);
        set_span(3, 100, 8, 103, 8, 2, 3);
        push_start(1, cyc + 2);
        push_ack(1, 3, 0, 2, 0);
        push_start(3, -1);
        push_ack(3, 4, 0, 2, 0);
        req = 4'b1010;
        wait_acks(1, 100);
        #1 req[1] = 1'b0;
        wait_acks(1, 100);
        #1 req = '0;

        repeat (5) @(posedge clk);
        #1;
        chk("pending_starts", sq.size(), 0);
        chk("pending_acks", aq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/span_scheduler.md
Name: span_scheduler

Overview:
- Shares one horizontal-span pixel writer between N_REQ span producers (triangle setup / edge walkers).
- Performs round-robin arbitration, latches the winning span, and issues a single start pulse to the writer.
- Counts the writer's plot pulses, watches for done, and returns a per-requester ack together with the span's pixel count.
- Filters degenerate spans and guards against a hung writer with a watchdog.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 16, coordinate/depth width.
- TIMEOUT, 4096, max cycles in WAIT before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester span request; held high with payload until ack.
- x0_in  in  N_REQ*W  span start x, requester i at bits [i*W +: W]; same packing for the next five ports.
- y0_in  in  N_REQ*W  span start y.
- x1_in  in  N_REQ*W  span end x (inclusive).
- y1_in  in  N_REQ*W  span end y.
- z1_in  in  N_REQ*W  depth at x0.
- z2_in  in  N_REQ*W  depth at x1.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- pix_count  out  W  pixels plotted for the acked span; valid while ack is high.
- span_start  out  1  one-cycle start to the writer.
- span_x0, span_y0, span_x1, span_y1, span_z1, span_z2  out  W each  latched payload; stable from LAUNCH until the next grant.
- span_plot  in  1  writer plot pulse.
- span_done  in  1  writer one-cycle done pulse.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(N_REQ)  index of the current or last grantee.
- timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - ack, span_start, busy, timeout_err, pix_count, grant_id, span_* and the rr pointer all clear to 0.
  - The hold-off mask clears.
  - Reset mid-span abandons the span with no ack; requesters re-present after reset.
- States:
  - IDLE: if (req & ~holdoff) != 0, select the first set bit searching upward from (rr_ptr+1) mod N_REQ with wrap, latch that requester's payload into span_*, set grant_id, go to CHECK. Otherwise stay.
  - CHECK: if x1 < x0 (unsigned), skip the writer: pix_count=0, go to RELEASE. Otherwise go to LAUNCH.
  - LAUNCH: span_start=1 for exactly this cycle; clear the plot counter and watchdog; go to WAIT.
  - WAIT:
    - Each cycle with span_plot high increments the plot counter (saturates at all-ones).
    - span_done high: pix_count = counter, plus 1 if span_plot is also high that cycle; go to RELEASE.
    - Watchdog reaching TIMEOUT-1 with no span_done: set timeout_err, pix_count = counter, go to RELEASE.
  - RELEASE: ack[grant_id]=1 for this cycle only; rr_ptr = grant_id; holdoff = one-hot(grant_id); go to IDLE.
- Hold-off:
  - holdoff masks only the IDLE cycle immediately after RELEASE, then clears.
  - This prevents regranting a requester that has not yet dropped req.
  - A requester still asserting req after that cycle is treated as a new span.
- Latency:
  - Request to span_start: 3 cycles (IDLE, CHECK, LAUNCH) when uncontended.
  - span_done to ack: 1 cycle.
  - Degenerate span: request to ack in 3 cycles.
- Other rules:
  - span_done or span_plot arriving outside WAIT is ignored.
  - Payload is sampled only in the IDLE grant cycle; later changes on the requester inputs are ignored.
  - y0/y1 are forwarded unchecked.
- Width: counter and comparisons are W bits unsigned; no arithmetic on coordinates beyond the x1<x0 compare.

Decomposition:
- Package span_sched_pkg holds:
  - typedef enum for the states IDLE, CHECK, LAUNCH, WAIT, RELEASE;
  - a span_t struct {x0,y0,x1,y1,z1,z2};
  - the default TIMEOUT constant.
- One sub-module, rr_arbiter: combinational round-robin pick from (req & ~holdoff) and rr_ptr, output valid + index. Parameterised on N_REQ.

Test Plan:
- Single span: req[0] with x0=10, x1=14, y=5, z1=0x100, z2=0x200; writer model plots 5 times then done -> span_start 3 cycles after req, span_x0=10, ack[0] one cycle after done, pix_count=5, busy low the following cycle.
- Fairness: req=4'b1111 held continuously, rr_ptr=0 after reset -> grant order 1,2,3,0,1, each acked once per round, no requester granted twice consecutively.
- Degenerate: req[2] with x0=20, x1=19 -> no span_start; ack[2] 3 cycles after req; pix_count=0.
- Hold-off: req[1] left high one cycle past its ack, no other req -> no regrant in the masked cycle; regrant on the next cycle as a new span.
- Watchdog: TIMEOUT=16, writer never asserts done after 3 plots -> ack at cycle 16 of WAIT, pix_count=3, timeout_err=1 and sticky until reset.
- Async reset in WAIT after 2 plots -> outputs zero immediately without a clock edge, no ack issued; after release a fresh req[3] is served normally starting from rr_ptr=0.
